// File: rtl/div_pkg.sv
// div_pkg: shared constants, result field offsets and state encoding for the multi-cycle divider
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam int LO_LSB    = 0;
    localparam int HI_LSB    = DIV_WIDTH;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } divState_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
//   rem, quo  in   partial remainder / dividend-quotient shift pair
//   divisor   in   divisor magnitude
//   remNext   out  remainder after shift and conditional subtract
//   quoNext   out  quotient shifted left with the new bit in the LSB
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        borrow  = shifted < {1'b0, divisor};
        // Without a borrow the true difference is below the divisor, so the low bits suffice
        diff    = shifted[WIDTH-1:0] - divisor;
        remNext = borrow ? shifted[WIDTH-1:0] : diff;
        quoNext = {quo[WIDTH-2:0], ~borrow};
    end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing FSM for a multi-cycle signed/unsigned restoring divider
//   clk, rst            clock, synchronous active-high reset
//   start, signed_div   divide request and DIV/DIVU select, sampled on accept
//   annul               cancel any operation in flight
//   opdata1, opdata2    dividend and divisor, sampled on accept
//   result              {remainder, quotient}, updated on entry to END
//   ready               one-cycle completion strobe
module div_ctrl import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);
    divState_t        state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, divisor, remStep, quoStep, mag1, mag2, remFix, quoFix;
    logic             negQuo, negRem, accept, lastStep;

    div_step #(.WIDTH(WIDTH)) step (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .remNext (remStep),
        .quoNext (quoStep)
    );

    assign mag1     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign mag2     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    assign accept   = state == DIV_IDLE && start && !annul;
    assign lastStep = cnt == CNT_W'(WIDTH - 1);
    assign remFix   = negRem ? -remStep : remStep;
    assign quoFix   = negQuo ? -quoStep : quoStep;

    always_comb begin
        stateNext = state;
        ready     = state == DIV_END && !annul;
        if (annul)
            stateNext = DIV_IDLE;
        else
            case (state)
                DIV_IDLE: stateNext = start ? (opdata2 == '0 ? DIV_ZERO : DIV_ON) : DIV_IDLE;
                DIV_ZERO: stateNext = DIV_END;
                DIV_ON:   stateNext = lastStep ? DIV_END : DIV_ON;
                default:  stateNext = DIV_IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            negQuo  <= 1'b0;
            negRem  <= 1'b0;
            result  <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                cnt     <= '0;
                rem     <= '0;
                quo     <= mag1;
                divisor <= mag2;
                negQuo  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                negRem  <= signed_div & opdata1[WIDTH-1];
            end else if (state == DIV_ON) begin
                cnt <= cnt + CNT_W'(1);
                rem <= remStep;
                quo <= quoStep;
            end
            if (!annul && state == DIV_ON && lastStep)
                result <= {remFix, quoFix};
            else if (!annul && state == DIV_ZERO)
                result <= '0;
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl against an arithmetic reference model
module tb_div_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic [63:0] result;
    logic        ready;
    int          total = 0;
    int          bad = 0;

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
        longint x, y, q, r;
        if (b == 0) return 64'd0;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one operation from IDLE; operands are scrambled after accept to prove they are latched.
    task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        lat        = -1;
        res        = '0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) begin
                start      = 1'b0;
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = $urandom_range(0, 1);
            end
            if (ready) begin
                lat = i;
                res = result;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++;
        if (result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat;
        doOp(32'd100, 32'd7, 1'b0, res, lat);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d want=33", lat); end
        total++;
        if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 got=%h want=%h", res, {32'd2, 32'd14}); end
        tick();
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL ready_one_cycle got=%b want=0", ready); end
        doOp(32'hFFFFFFFF, 32'd1, 1'b0, res, lat);
        total++;
        if (res !== {32'd0, 32'hFFFFFFFF}) begin bad++; $display("FAIL divu_max_1 got=%h want=%h", res, {32'd0, 32'hFFFFFFFF}); end
        tick();
    endtask

    task automatic test_signed();
        logic [31:0] as [3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs [3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [63:0] want [3] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD}, {32'd0, 32'h80000000}};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            doOp(as[i], bs[i], 1'b1, res, lat);
            total++;
            if (res !== want[i] || lat !== 33) begin
                bad++;
                $display("FAIL div_signed_%0d got=%h lat=%0d want=%h lat=33", i, res, lat, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        int lat;
        doOp(32'd1234, 32'd0, 1'b0, res, lat);
        total++;
        if (lat !== 2 || res !== 64'd0) begin bad++; $display("FAIL div_zero got=%h lat=%0d want=0 lat=2", res, lat); end
        tick();
        doOp(32'hFFFFFFFF, 32'd1, 1'b0, res, lat);
        total++;
        if (res !== {32'd0, 32'hFFFFFFFF} || lat !== 33) begin bad++; $display("FAIL after_zero got=%h lat=%0d", res, lat); end
        tick();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat, highs;
        opdata1 = 32'd1000;
        opdata2 = 32'd7;
        signed_div = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        annul = 1'b1;
        #1;
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL annul_same_cycle got=%b want=0", ready); end
        tick();
        annul = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) highs++;
            tick();
        end
        total++;
        if (highs !== 0) begin bad++; $display("FAIL annul_quiet got=%0d want=0", highs); end
        doOp(32'd9, 32'd3, 1'b0, res, lat);
        total++;
        if (res !== {32'd0, 32'd3} || lat !== 33) begin bad++; $display("FAIL after_annul got=%h lat=%0d want=%h lat=33", res, lat, {32'd0, 32'd3}); end
        tick();
        doOp(32'd50, 32'd6, 1'b0, res, lat);
        annul = 1'b1;
        #1;
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL annul_in_end got=%b want=0", ready); end
        tick();
        annul = 1'b0;
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL annul_end_next got=%b want=0", ready); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        opdata1 = 32'd77777;
        opdata2 = 32'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin bad++; $display("FAIL reset_mid got=%b/%h want=0/0", ready, result); end
        doOp(32'd50, 32'd5, 1'b0, res, lat);
        total++;
        if (res !== {32'd0, 32'd10} || lat !== 33) begin bad++; $display("FAIL after_reset got=%h lat=%0d", res, lat); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin bad++; $display("FAIL reset_end got=%b/%h want=0/0", ready, result); end
        tick();
    endtask

    task automatic test_back_to_back();
        int t1, t2, cyc;
        opdata1 = 32'd1000;
        opdata2 = 32'd9;
        signed_div = 1'b0;
        start = 1'b1;
        t1 = -1;
        t2 = -1;
        cyc = 0;
        while (cyc < 120 && t2 < 0) begin
            tick();
            cyc++;
            if (ready && t1 < 0) begin
                t1 = cyc;
                total++;
                if (result !== model(32'd1000, 32'd9, 1'b0)) begin bad++; $display("FAIL b2b_first got=%h want=%h", result, model(32'd1000, 32'd9, 1'b0)); end
                opdata1 = 32'hFFFFFF00;
                opdata2 = 32'd16;
                signed_div = 1'b1;
            end else if (ready) begin
                t2 = cyc;
                start = 1'b0;
                total++;
                if (result !== model(32'hFFFFFF00, 32'd16, 1'b1)) begin bad++; $display("FAIL b2b_second got=%h want=%h", result, model(32'hFFFFFF00, 32'd16, 1'b1)); end
            end
        end
        start = 1'b0;
        total++;
        if (t1 < 0 || t2 - t1 !== 34) begin bad++; $display("FAIL b2b_spacing got=%0d want=34", t2 - t1); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s;
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = (i % 6 == 0) ? 32'd0 : (i % 4 == 0) ? {31'd0, 1'b1} << $urandom_range(0, 31) : $urandom >> $urandom_range(0, 31);
            s = $urandom_range(0, 1);
            doOp(a, b, s, res, lat);
            total++;
            if (res !== model(a, b, s) || lat !== (b == 0 ? 2 : 33)) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h s=%b got=%h lat=%0d want=%h", i, a, b, s, res, lat, model(a, b, s));
            end
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
